// File: rtl/syn_branch_predict_unit_pkg.sv
// Shared encodings and helpers for the branch predict unit.
package syn_branch_predict_unit_pkg;

  localparam int unsigned BPU_TYPE_BIT = 2;
  localparam int unsigned STAT_W       = 32;

  localparam logic [BPU_TYPE_BIT-1:0] BPU_TYPE_BR   = 2'd0;
  localparam logic [BPU_TYPE_BIT-1:0] BPU_TYPE_JMP  = 2'd1;
  localparam logic [BPU_TYPE_BIT-1:0] BPU_TYPE_CALL = 2'd2;
  localparam logic [BPU_TYPE_BIT-1:0] BPU_TYPE_RET  = 2'd3;

  // Saturating increment for the statistics counters.
  function automatic logic [STAT_W-1:0] stat_inc(input logic [STAT_W-1:0] v);
    return (v == '1) ? v : v + STAT_W'(1);
  endfunction

endpackage

// File: rtl/syn_bpu_ras.sv
// Return-address stack: circular buffer, push overwrites the oldest when full.
module syn_bpu_ras
  import syn_branch_predict_unit_pkg::*;
#(
  parameter int unsigned RAS_DEPTH = 4,
  parameter int unsigned PC_W      = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            clr,
  input  logic            push,
  input  logic            pop,
  input  logic [PC_W-1:0] push_data,
  output logic [PC_W-1:0] top,
  output logic            empty
);

  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PC_W-1:0]  stack_q [RAS_DEPTH];
  logic [PTR_W-1:0] ptr_q;
  logic [CNT_W-1:0] cnt_q;

  // ptr_q is the next free slot; the top lives just below it (mod depth).
  assign top   = stack_q[ptr_q - PTR_W'(1)];
  assign empty = (cnt_q == '0);

  // Stack storage, pointer and occupancy; clr drops the occupancy only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < int'(RAS_DEPTH); i++) stack_q[i] <= '0;
    end else if (en) begin
      if (clr) begin
        cnt_q <= '0;
      end else if (push) begin
        stack_q[ptr_q] <= push_data;
        ptr_q          <= ptr_q + PTR_W'(1);
        if (cnt_q != CNT_W'(RAS_DEPTH)) cnt_q <= cnt_q + CNT_W'(1);
      end else if (pop && !empty) begin
        ptr_q <= ptr_q - PTR_W'(1);
        cnt_q <= cnt_q - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/syn_branch_predict_unit.sv
// Tagged direct-mapped BTB with saturating counters, RAS and stats.
module syn_branch_predict_unit
  import syn_branch_predict_unit_pkg::*;
#(
  parameter int unsigned PC_W      = 32,
  parameter int unsigned IDX_W     = 6,
  parameter int unsigned TAG_W     = 8,
  parameter int unsigned CNT_W     = 2,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    clr,
  input  logic [PC_W-1:0]         lk_pc,
  input  logic [PC_W-1:0]         lk_pc_next,
  output logic                    pred_hit,
  output logic                    pred_taken,
  output logic [PC_W-1:0]         pred_target,
  input  logic                    upd_valid,
  input  logic [PC_W-1:0]         upd_pc,
  input  logic [PC_W-1:0]         upd_pc_next,
  input  logic [PC_W-1:0]         upd_target,
  input  logic                    upd_taken,
  input  logic [BPU_TYPE_BIT-1:0] upd_type,
  input  logic                    upd_mispredict,
  output logic                    ras_empty,
  output logic [STAT_W-1:0]       stat_updates,
  output logic [STAT_W-1:0]       stat_mispred
);

  localparam int unsigned     ENTRIES  = 2 ** IDX_W;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(2 ** (CNT_W - 1) - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic                    valid_q  [ENTRIES];
  logic [TAG_W-1:0]        tag_q    [ENTRIES];
  logic [CNT_W-1:0]        cnt_q    [ENTRIES];
  logic [BPU_TYPE_BIT-1:0] type_q   [ENTRIES];
  logic [PC_W-1:0]         target_q [ENTRIES];

  logic [STAT_W-1:0] stat_updates_q, stat_mispred_q;

  logic [IDX_W-1:0] lk_idx, upd_idx;
  logic [TAG_W-1:0] lk_tag, upd_tag;
  logic             upd_hit, upd_acc;
  logic [CNT_W-1:0] cnt_d;
  logic [PC_W-1:0]  ras_top;
  logic             ras_push, ras_pop;

  assign lk_idx  = lk_pc[IDX_W-1:0];
  assign lk_tag  = lk_pc[IDX_W+TAG_W-1:IDX_W];
  assign upd_idx = upd_pc[IDX_W-1:0];
  assign upd_tag = upd_pc[IDX_W+TAG_W-1:IDX_W];

  // PC bits above the tag do not participate in the lookup.
  if (IDX_W + TAG_W < PC_W) begin : g_hi_bits
    logic unused_hi;
    assign unused_hi = ^{lk_pc[PC_W-1:IDX_W+TAG_W], upd_pc[PC_W-1:IDX_W+TAG_W]};
  end

  // Combinational IF lookup against the pre-edge table contents.
  always_comb begin
    pred_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    pred_taken  = pred_hit && ((type_q[lk_idx] != BPU_TYPE_BR) || cnt_q[lk_idx][CNT_W-1]);
    pred_target = lk_pc_next;
    if (pred_taken) begin
      if ((type_q[lk_idx] == BPU_TYPE_RET) && !ras_empty) pred_target = ras_top;
      else                                               pred_target = target_q[lk_idx];
    end
  end

  // Update qualification and saturating counter step from the stored counter.
  always_comb begin
    upd_acc = en && upd_valid && !clr;
    upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    cnt_d   = cnt_q[upd_idx];
    if (upd_taken) begin
      if (cnt_q[upd_idx] != CNT_MAX) cnt_d = cnt_q[upd_idx] + CNT_W'(1);
    end else begin
      if (cnt_q[upd_idx] != '0) cnt_d = cnt_q[upd_idx] - CNT_W'(1);
    end
  end

  // BTB table writes: clr invalidates, otherwise train on hit or allocate on taken miss.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        cnt_q[i]    <= CNT_INIT;
        type_q[i]   <= BPU_TYPE_BR;
        target_q[i] <= '0;
      end
    end else if (en) begin
      if (clr) begin
        for (int i = 0; i < int'(ENTRIES); i++) valid_q[i] <= 1'b0;
      end else if (upd_valid) begin
        if (upd_hit) begin
          cnt_q[upd_idx]  <= cnt_d;
          type_q[upd_idx] <= upd_type;
          if (upd_taken) target_q[upd_idx] <= upd_target;
        end else if (upd_taken) begin
          valid_q[upd_idx]  <= 1'b1;
          tag_q[upd_idx]    <= upd_tag;
          cnt_q[upd_idx]    <= CNT_INIT + CNT_W'(1);
          type_q[upd_idx]   <= upd_type;
          target_q[upd_idx] <= upd_target;
        end
      end
    end
  end

  // Saturating statistics on accepted updates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_updates_q <= '0;
      stat_mispred_q <= '0;
    end else if (upd_acc) begin
      stat_updates_q <= stat_inc(stat_updates_q);
      if (upd_mispredict) stat_mispred_q <= stat_inc(stat_mispred_q);
    end
  end

  assign stat_updates = stat_updates_q;
  assign stat_mispred = stat_mispred_q;

  assign ras_push = upd_acc && upd_taken && (upd_type == BPU_TYPE_CALL);
  assign ras_pop  = upd_acc && upd_taken && (upd_type == BPU_TYPE_RET);

  syn_bpu_ras #(
    .RAS_DEPTH (RAS_DEPTH),
    .PC_W      (PC_W)
  ) u_ras (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .clr       (clr),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (upd_pc_next),
    .top       (ras_top),
    .empty     (ras_empty)
  );

endmodule
